// File: rtl/alu_op_pkg.sv
// Shared opcode encoding, command layout and reference ALU model for the
// ALU operation issuer and its bench.
package alu_op_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_SUB = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

    localparam int CMD_DATA_W = 4;

    typedef struct packed {
        alu_op_e                code;
        logic [CMD_DATA_W-1:0]  a;
        logic [CMD_DATA_W-1:0]  b;
    } alu_cmd_t;

    // Computed at 32 bits; callers mask to their operand width, which gives
    // the mod 2^W wrap for SUB/ADD without reporting carry or borrow.
    function automatic logic [31:0] alu_ref(input logic [1:0]  code,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (code)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SUB:  r = a - b;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push is refused when full even if a pop occurs
// on the same edge, so ready depends only on the registered occupancy.
module alu_cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_en, pop_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues buffered commands to a combinational ALU one at a time, returns each
// sampled result on a valid/ready channel and flags disagreement with alu_ref.
module alu_op_issuer
    import alu_op_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // Both channels: a transfer happens on an edge where valid && ready;
    // the sender holds its payload stable while valid && !ready.
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_code_i,
    input  logic [DATA_W-1:0]             cmd_a_i,
    input  logic [DATA_W-1:0]             cmd_b_i,
    output logic [1:0]                    alu_code_o,
    output logic [DATA_W-1:0]             alu_a_o,
    output logic [DATA_W-1:0]             alu_b_o,
    input  logic [DATA_W-1:0]             alu_c_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [1:0]                    rsp_code_o,
    output logic [DATA_W-1:0]             rsp_c_o,
    output logic                          rsp_err_o,
    output logic                          err_sticky_o,
    output logic [7:0]                    mismatch_cnt_o,
    output logic [7:0]                    op_cnt_o,
    output logic [1:0]                    state_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int          CMD_W  = 2 + 2 * DATA_W;
    localparam logic [31:0] C_MASK = 32'((64'd1 << DATA_W) - 64'd1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        alu_code_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [1:0]        rsp_code_q;
    logic [DATA_W-1:0] rsp_c_q;
    logic              rsp_err_q, err_sticky_q;
    logic [7:0]        mismatch_cnt_q, op_cnt_q;

    logic              fifo_full, fifo_empty, pop;
    logic [CMD_W-1:0]  fifo_head;
    logic [31:0]       ref_c;
    logic              mismatch, rsp_fire;

    alu_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid_i),
        .data_i  ({cmd_code_i, cmd_a_i, cmd_b_i}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_fire = (state_q == ST_RESP) && rsp_ready_i;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The alu_* registers have been stable for the whole DRIVE cycle, so the
    // reference is evaluated on the same operands the external ALU saw.
    assign ref_c    = alu_ref(alu_code_q, 32'(alu_a_q), 32'(alu_b_q)) & C_MASK;
    assign mismatch = (32'(alu_c_i) != ref_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            alu_code_q     <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            rsp_code_q     <= '0;
            rsp_c_q        <= '0;
            rsp_err_q      <= 1'b0;
            err_sticky_q   <= 1'b0;
            mismatch_cnt_q <= '0;
            op_cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                {alu_code_q, alu_a_q, alu_b_q} <= fifo_head;
            end
            if (state_q == ST_DRIVE) begin
                rsp_c_q    <= alu_c_i;
                rsp_code_q <= alu_code_q;
                rsp_err_q  <= mismatch;
                if (mismatch) begin
                    err_sticky_q <= 1'b1;
                    if (mismatch_cnt_q != 8'hFF) begin
                        mismatch_cnt_q <= mismatch_cnt_q + 8'd1;
                    end
                end
            end
            if (rsp_fire) begin
                op_cnt_q <= op_cnt_q + 8'd1;
            end
        end
    end

    assign cmd_ready_o    = !fifo_full;
    assign alu_code_o     = alu_code_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_code_o     = rsp_code_q;
    assign rsp_c_o        = rsp_c_q;
    assign rsp_err_o      = rsp_err_q;
    assign err_sticky_o   = err_sticky_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
    assign op_cnt_o       = op_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: a behavioural ALU with optional fault on OR, a
// response scoreboard, and one task per scenario.
module tb_alu_op_issuer;
    import alu_op_pkg::*;

    localparam int EW = 7;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_code = 2'b00;
    logic [3:0] cmd_a = 4'h0, cmd_b = 4'h0;
    logic [1:0] alu_code;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [1:0] rsp_code;
    logic [3:0] rsp_c;
    logic       rsp_err, err_sticky;
    logic [7:0] mismatch_cnt, op_cnt;
    logic [1:0] state;
    logic [2:0] fifo_count;
    logic       fault_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];
    bit  gap_check = 1'b0;
    int  last_rsp_cyc = -1;

    alu_op_issuer #(.DATA_W(4), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_code_i     (cmd_code),
        .cmd_a_i        (cmd_a),
        .cmd_b_i        (cmd_b),
        .alu_code_o     (alu_code),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_c_i        (alu_c),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_code_o     (rsp_code),
        .rsp_c_o        (rsp_c),
        .rsp_err_o      (rsp_err),
        .err_sticky_o   (err_sticky),
        .mismatch_cnt_o (mismatch_cnt),
        .op_cnt_o       (op_cnt),
        .state_o        (state),
        .fifo_count_o   (fifo_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] bench_alu(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a - b;
            default: return a + b;
        endcase
    endfunction

    always_comb alu_c = bench_alu(alu_code, alu_a, alu_b) ^ {3'b000, (fault_en && alu_code == 2'b01)};

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got code=%0d c=%h err=%0b, required no response",
                         rsp_code, rsp_c, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_code, rsp_c, rsp_err} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got code=%0d c=%h err=%0b, required code=%0d c=%h err=%0b",
                             rsp_code, rsp_c, rsp_err, e[6:5], e[4:1], e[0]);
                end
            end
            if (gap_check && last_rsp_cyc >= 0) begin
                checks++;
                if (cyc - last_rsp_cyc != 2) begin
                    errors++;
                    $display("FAIL rsp_spacing: got %0d cycles, required 2", cyc - last_rsp_cyc);
                end
            end
            last_rsp_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int budget;
        logic f;
        budget = 0;
        f = fault_en && (op == 2'b01);
        cmd_valid = 1'b1;
        cmd_code  = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready=%0b, required 1 within 200 cycles", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back({op, bench_alu(op, a, b) ^ {3'b000, f}, f});
            step();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rsp_valid) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0 || rsp_valid) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d rsp_valid=%0b, required 0 and 0",
                     exp_q.size(), rsp_valid);
        end
        step();
    endtask

    task automatic wait_rsp_valid();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!rsp_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_valid_timeout: got %0b, required 1", rsp_valid);
        end
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [35:0] obs;
        repeat (2) @(posedge clk);
        #1;
        obs = {cmd_ready, rsp_valid, alu_code, alu_a, alu_b, rsp_code, rsp_c, rsp_err,
               err_sticky, mismatch_cnt, op_cnt};
        checks++;
        if (obs !== {1'b1, 35'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h, required %h", obs, {1'b1, 35'd0});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        push_cmd(OP_SUB, 4'h3, 4'h5);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: rsp_valid=%0b, required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({state, rsp_valid, alu_code, alu_a, alu_b} !== {S_DRIVE, 1'b0, 2'b10, 4'h3, 4'h5}) begin
            errors++;
            $display("FAIL single_drive: got state=%0d v=%0b code=%0d a=%h b=%h, required 1 0 2 3 5",
                     state, rsp_valid, alu_code, alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_c, rsp_err} !== {1'b1, 4'hE, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got v=%0b c=%h err=%0b, required 1 E 0", rsp_valid, rsp_c, rsp_err);
        end
        @(negedge clk);
        checks++;
        if ({op_cnt, rsp_valid, alu_a, alu_b} !== {8'd1, 1'b0, 4'h3, 4'h5}) begin
            errors++;
            $display("FAIL single_after: got op_cnt=%0d v=%0b a=%h b=%h, required 1 0 3 5",
                     op_cnt, rsp_valid, alu_a, alu_b);
        end
        step();
    endtask

    task automatic test_back_to_back();
        rsp_ready    = 1'b1;
        gap_check    = 1'b1;
        last_rsp_cyc = -1;
        push_cmd(OP_ADD, 4'hF, 4'h1);
        push_cmd(OP_AND, 4'hC, 4'hA);
        push_cmd(OP_OR,  4'h5, 4'hA);
        push_cmd(OP_SUB, 4'h0, 4'h1);
        push_cmd(OP_ADD, 4'h7, 4'h8);
        wait_drain();
        gap_check = 1'b0;
        checks++;
        if (op_cnt !== 8'd6) begin
            errors++;
            $display("FAIL burst_op_cnt: got %0d, required 6", op_cnt);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 4'h2, 4'h3);
        wait_rsp_valid();
        push_cmd(OP_AND, 4'h6, 4'h3);
        push_cmd(OP_OR,  4'h8, 4'h1);
        push_cmd(OP_SUB, 4'h2, 4'h7);
        push_cmd(OP_ADD, 4'h9, 4'h9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_code, rsp_c, rsp_err, alu_code, alu_a, alu_b, cmd_ready} !==
                {1'b1, 2'b11, 4'h5, 1'b0, 2'b11, 4'h2, 4'h3, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0b code=%0d c=%h err=%0b alu=%0d/%h/%h rdy=%0b, required 1 3 5 0 3/2/3 0",
                         i, rsp_valid, rsp_code, rsp_c, rsp_err, alu_code, alu_a, alu_b, cmd_ready);
            end
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_still_full: got %0b, required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_reassert: got %0b, required 1", cmd_ready);
        end
        wait_drain();
    endtask

    task automatic test_fault();
        rsp_ready = 1'b1;
        fault_en  = 1'b1;
        push_cmd(OP_OR, 4'h1, 4'h2);
        push_cmd(OP_ADD, 4'h3, 4'h4);
        wait_drain();
        fault_en = 1'b0;
        checks++;
        if ({err_sticky, mismatch_cnt, rsp_err} !== {1'b1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL fault_status: got sticky=%0b cnt=%0d err=%0b, required 1 1 0",
                     err_sticky, mismatch_cnt, rsp_err);
        end
    endtask

    task automatic test_reset_midop();
        logic [35:0] obs;
        int budget;
        rsp_ready = 1'b0;
        push_cmd(OP_ADD, 4'h1, 4'h1);
        wait_rsp_valid();
        push_cmd(OP_ADD, 4'h1, 4'h2);
        push_cmd(OP_OR,  4'h3, 4'h4);
        push_cmd(OP_AND, 4'h5, 4'h6);
        push_cmd(OP_SUB, 4'h7, 4'h8);
        rsp_ready = 1'b1;
        budget = 0;
        @(negedge clk);
        while (state !== S_DRIVE && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (state !== S_DRIVE || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL midop_setup: got state=%0d count=%0d, required 1 3", state, fifo_count);
        end
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        obs = {cmd_ready, rsp_valid, alu_code, alu_a, alu_b, rsp_code, rsp_c, rsp_err,
               err_sticky, mismatch_cnt, op_cnt};
        checks++;
        if (obs !== {1'b1, 35'd0} || state !== S_IDLE || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL midop_reset: got %h state=%0d count=%0d, required %h 0 0",
                     obs, state, fifo_count, {1'b1, 35'd0});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || state !== S_IDLE) begin
                errors++;
                $display("FAIL midop_quiet[%0d]: got v=%0b state=%0d, required 0 0", i, rsp_valid, state);
            end
        end
        step();
        push_cmd(OP_ADD, 4'h4, 4'h4);
        wait_drain();
        checks++;
        if (op_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midop_op_cnt: got %0d, required 1", op_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            push_cmd(OP_ADD, 4'h0, 4'h0);
        end
        wait_drain();
        checks++;
        if (op_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d, required 255", op_cnt);
        end
        push_cmd(OP_ADD, 4'h0, 4'h0);
        wait_drain();
        checks++;
        if ({op_cnt, mismatch_cnt, err_sticky} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_zero: got op_cnt=%0d mismatch=%0d sticky=%0b, required 0 0 0",
                     op_cnt, mismatch_cnt, err_sticky);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fault();
        test_reset_midop();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
